// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word reads for the current PC under a credit scheme,
// tracks in-flight request PCs, and buffers returned instructions for decode.
module instr_fetch #(
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic                  pc_ready,
  input  logic                  flush,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  localparam logic [OW-1:0] OUT_ZERO_C = {OW{1'b0}};
  localparam logic [OW-1:0] OUT_ONE_C  = OW'(1'b1);
  localparam logic [OW-1:0] MAX_OUT_C  = OW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CNT_ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE_C  = CW'(1'b1);
  localparam logic [SW-1:0] DEPTH_C    = SW'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ZERO_C = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE_C  = AW'(1'b1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic                  init_q;
  logic                  valid_q;
  logic [OW-1:0]         out_q, out_d;
  logic [OW-1:0]         kill_q, kill_d;
  logic [OW-1:0]         pcq_wr_idx_s;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] pcq_q       [MAX_OUTSTANDING];
  logic [DATA_WIDTH-1:0] pcq_d       [MAX_OUTSTANDING];

  logic rsp_s;
  logic grant_s;
  logic push_s;
  logic pop_s;
  logic credit_s;
  logic pc_lsb_unused_s;

  // Every granted read owns a FIFO slot, so responses never need back-pressure.
  assign credit_s  = (SW'(cnt_q) + SW'(out_q)) < DEPTH_C;
  assign imem_addr = {pc_i[DATA_WIDTH-1:2], 2'b00};
  assign imem_req  = rst && init_q && (state_q == RUN) && !flush &&
                     (out_q < MAX_OUT_C) && credit_s;
  assign pc_ready  = imem_req && imem_gnt;
  assign grant_s   = pc_ready;

  // A response with nothing outstanding is a stale reply from before reset.
  assign rsp_s  = imem_rvalid && (out_q != OUT_ZERO_C);
  assign push_s = rsp_s && (kill_q == OUT_ZERO_C) && !flush;
  assign pop_s  = valid_q && instr_ready && !flush;

  assign instr_valid = valid_q;
  assign instr_o     = fifo_data_q[rd_ptr_q];
  assign instr_pc_o  = fifo_pc_q[rd_ptr_q];

  assign pc_lsb_unused_s = ^pc_i[1:0];

  // Redirect bookkeeping: how many in-flight replies still belong to the old path.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    if (flush) begin
      kill_d = out_q - OW'(rsp_s);
      if (kill_d != OUT_ZERO_C) begin
        state_d = DRAIN;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          state_d = RUN;
          kill_d  = OUT_ZERO_C;
        end
        DRAIN: begin
          if (rsp_s) begin
            kill_d = kill_q - OUT_ONE_C;
          end else begin
            kill_d = kill_q;
          end
          if (kill_d == OUT_ZERO_C) begin
            state_d = RUN;
          end else begin
            state_d = DRAIN;
          end
        end
        default: begin
          state_d = RUN;
          kill_d  = OUT_ZERO_C;
        end
      endcase
    end
  end

  // Outstanding-read counter and instruction FIFO pointers/occupancy.
  always_comb begin
    out_d    = out_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case ({grant_s, rsp_s})
      2'b10:   out_d = out_q + OUT_ONE_C;
      2'b01:   out_d = out_q - OUT_ONE_C;
      default: out_d = out_q;
    endcase
    if (flush) begin
      cnt_d    = CNT_ZERO_C;
      wr_ptr_d = PTR_ZERO_C;
      rd_ptr_d = PTR_ZERO_C;
    end else begin
      wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE_C) : wr_ptr_q;
      rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE_C) : rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + CNT_ONE_C;
        2'b01:   cnt_d = cnt_q - CNT_ONE_C;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Request PC queue: entry 0 is the oldest in-flight read; new grants land after the survivors.
  always_comb begin
    pcq_wr_idx_s = out_q - OW'(rsp_s);
    for (int i = 0; i < MAX_OUTSTANDING - 1; i++) begin
      pcq_d[i] = rsp_s ? pcq_q[i+1] : pcq_q[i];
    end
    pcq_d[MAX_OUTSTANDING-1] = pcq_q[MAX_OUTSTANDING-1];
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      pcq_d[i] = (grant_s && (OW'(i) == pcq_wr_idx_s)) ? imem_addr : pcq_d[i];
    end
  end

  // Control state; init_q holds off requests for the first cycle after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RUN;
      init_q   <= 1'b0;
      valid_q  <= 1'b0;
      out_q    <= OUT_ZERO_C;
      kill_q   <= OUT_ZERO_C;
      cnt_q    <= CNT_ZERO_C;
      wr_ptr_q <= PTR_ZERO_C;
      rd_ptr_q <= PTR_ZERO_C;
    end else begin
      state_q  <= state_d;
      init_q   <= 1'b1;
      valid_q  <= (cnt_d != CNT_ZERO_C);
      out_q    <= out_d;
      kill_q   <= kill_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Instruction buffer and request PC storage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= {DATA_WIDTH{1'b0}};
        fifo_pc_q[i]   <= {DATA_WIDTH{1'b0}};
      end
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        pcq_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_data_q[wr_ptr_q] <= imem_rdata;
        fifo_pc_q[wr_ptr_q]   <= pcq_q[0];
      end
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        pcq_q[i] <= pcq_d[i];
      end
    end
  end

endmodule
